input_conditioner: RTL and testbench

INPUT_CONDITIONER -- requirements
Module: input_conditioner

---
 rtl/input_cond_pkg.sv | 22 ++
 rtl/input_conditioner_if.sv | 24 ++
 rtl/debounce_filter.sv | 55 +++++
 rtl/input_conditioner.sv | 139 +++++++++++++
 tb/tb_input_conditioner.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/input_cond_pkg.sv
// Shared FSM state type, default timing constants and helpers for input_conditioner.
// LONG_HELD exists only when INPUT_COND_LONG_PRESS_EN is defined.
package input_cond_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES   = 1250000;
  localparam int DEFAULT_LONG_PRESS_CYCLES = 125000000;
  localparam int HOLD_CNT_W                = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1
`ifdef INPUT_COND_LONG_PRESS_EN
    ,
    LONG_HELD = 2'd2
`endif
  } btn_state_e;

  function automatic logic [HOLD_CNT_W-1:0] sat_inc(input logic [HOLD_CNT_W-1:0] v);
    return (v == {HOLD_CNT_W{1'b1}}) ? v : v + HOLD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/input_conditioner_if.sv
// Raw button/switch inputs and conditioned outputs of input_conditioner.
// master drives the raw pins, slave is the conditioner itself.
interface input_conditioner_if;

  logic       btn;
  logic [1:0] switches;
  logic [1:0] sw_stable;
  logic       sw_changed;
  logic       btn_short;
  logic       btn_long;
  logic       cnt_en;
  logic       cnt_rst;

  modport master (
    output btn, switches,
    input  sw_stable, sw_changed, btn_short, btn_long, cnt_en, cnt_rst
  );

  modport slave (
    input  btn, switches,
    output sw_stable, sw_changed, btn_short, btn_long, cnt_en, cnt_rst
  );

endinterface

// File: rtl/debounce_filter.sv
// Two-flop synchronizer followed by a stable-count debouncer for one raw input.
// dout only follows din after DEBOUNCE_CYCLES consecutive differing synchronized samples.
module debounce_filter
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int              CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;

  // metastability guard on the asynchronous pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], din};
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync_q[1];
      cnt_d    = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= {CNT_W{1'b0}};
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounced button short/long-press decoder and switch-change detector driving a counter enable/clear.
// Long-press detection is compiled in with INPUT_COND_LONG_PRESS_EN; without it every release is a short press.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
  input  logic               clk,
  input  logic               rst_n,
  input_conditioner_if.slave io
);

  logic       btn_db_s;
  logic [1:0] sw_db_s;

  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
    .clk(clk), .rst_n(rst_n), .din(io.btn), .dout(btn_db_s)
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw0_db (
    .clk(clk), .rst_n(rst_n), .din(io.switches[0]), .dout(sw_db_s[0])
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw1_db (
    .clk(clk), .rst_n(rst_n), .din(io.switches[1]), .dout(sw_db_s[1])
  );

  btn_state_e state_q, state_d;
  logic       btn_short_q, btn_short_d;
  logic       btn_long_q, btn_long_d;
  logic       cnt_en_q, cnt_en_d;
  logic       cnt_rst_q, cnt_rst_d;
  logic       sw_changed_q, sw_changed_d;
  logic [1:0] sw_prev_q;

`ifdef INPUT_COND_LONG_PRESS_EN
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(LONG_PRESS_CYCLES - 1);
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
`else
  logic unused_long_s;
  assign unused_long_s = ^HOLD_CNT_W'(LONG_PRESS_CYCLES);
`endif

  // Switch changes never touch cnt_en/cnt_rst, so a coinciding long press always wins.
  assign sw_changed_d = (sw_db_s != sw_prev_q);

  always_comb begin
    state_d     = state_q;
    btn_short_d = 1'b0;
    btn_long_d  = 1'b0;
    cnt_rst_d   = 1'b0;
    cnt_en_d    = cnt_en_q;
`ifdef INPUT_COND_LONG_PRESS_EN
    hold_d      = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (btn_db_s) begin
          state_d = PRESSED;
`ifdef INPUT_COND_LONG_PRESS_EN
          hold_d  = {HOLD_CNT_W{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      PRESSED: begin
`ifdef INPUT_COND_LONG_PRESS_EN
        if (hold_q == HOLD_LAST) begin
          state_d    = LONG_HELD;
          btn_long_d = 1'b1;
          cnt_rst_d  = 1'b1;
          cnt_en_d   = 1'b0;
        end else if (!btn_db_s) begin
          state_d     = IDLE;
          btn_short_d = 1'b1;
          cnt_en_d    = ~cnt_en_q;
        end else begin
          hold_d = sat_inc(hold_q);
        end
`else
        if (!btn_db_s) begin
          state_d     = IDLE;
          btn_short_d = 1'b1;
          cnt_en_d    = ~cnt_en_q;
        end else begin
          state_d = PRESSED;
        end
`endif
      end
`ifdef INPUT_COND_LONG_PRESS_EN
      LONG_HELD: begin
        if (!btn_db_s) begin
          state_d = IDLE;
        end else begin
          state_d = LONG_HELD;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state, hold counter and registered pulse/level outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      btn_short_q  <= 1'b0;
      btn_long_q   <= 1'b0;
      cnt_en_q     <= 1'b0;
      cnt_rst_q    <= 1'b0;
      sw_changed_q <= 1'b0;
      sw_prev_q    <= 2'b00;
`ifdef INPUT_COND_LONG_PRESS_EN
      hold_q       <= {HOLD_CNT_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      btn_short_q  <= btn_short_d;
      btn_long_q   <= btn_long_d;
      cnt_en_q     <= cnt_en_d;
      cnt_rst_q    <= cnt_rst_d;
      sw_changed_q <= sw_changed_d;
      sw_prev_q    <= sw_db_s;
`ifdef INPUT_COND_LONG_PRESS_EN
      hold_q       <= hold_d;
`endif
    end
  end

  assign io.sw_stable  = sw_db_s;
  assign io.sw_changed = sw_changed_q;
  assign io.btn_short  = btn_short_q;
  assign io.btn_long   = btn_long_q;
  assign io.cnt_en     = cnt_en_q;
  assign io.cnt_rst    = cnt_rst_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with a press-duration reference model.
// Long-press expectations follow INPUT_COND_LONG_PRESS_EN.
module tb_input_conditioner;

  localparam int D  = 4;
  localparam int LP = 20;
`ifdef INPUT_COND_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  input_conditioner_if io();

  input_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(LP)) dut (
    .clk(clk), .rst_n(rst_n), .io(io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: pin history window, debounced levels, high-time of the debounced button
  logic [2:0] hist [1:D+1];
  logic [2:0] m_db;
  logic [1:0] m_prev_sw;
  int         m_h;
  logic       m_short, m_long, m_rst, m_en, m_chg;

  task automatic model_reset();
    for (int k = 1; k <= D + 1; k++) hist[k] = 3'b000;
    m_db = 3'b000; m_prev_sw = 2'b00; m_h = 0;
    m_short = 1'b0; m_long = 1'b0; m_rst = 1'b0; m_en = 1'b0; m_chg = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] cur;
    logic       all_diff;
    if (!rst_n) begin
      model_reset();
    end else begin
      cur = {io.switches, io.btn};
      m_chg = (m_db[2:1] != m_prev_sw);
      m_prev_sw = m_db[2:1];
      m_short = 1'b0; m_long = 1'b0; m_rst = 1'b0;
      if (LP_EN && m_h == LP) begin
        m_long = 1'b1; m_rst = 1'b1; m_en = 1'b0;
      end else if (!m_db[0] && m_h > 0 && (!LP_EN || m_h < LP)) begin
        m_short = 1'b1; m_en = ~m_en;
      end
      m_h = m_db[0] ? m_h + 1 : 0;
      // a level is accepted once the last D synchronized samples all disagree with it
      for (int b = 0; b < 3; b++) begin
        all_diff = 1'b1;
        for (int k = 2; k <= D + 1; k++) if (hist[k][b] == m_db[b]) all_diff = 1'b0;
        if (all_diff) m_db[b] = ~m_db[b];
      end
      for (int k = D + 1; k > 1; k--) hist[k] = hist[k-1];
      hist[1] = cur;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] got;
    rst_n = 1'b0;
    model_reset();
    repeat (3) tick();
    got = {io.sw_stable, io.sw_changed, io.btn_short, io.btn_long, io.cnt_en, io.cnt_rst};
    checks++;
    if (got !== 7'b0000000) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", got, 7'b0000000);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_glitch();
    logic [6:0] got, exp;
    logic en_before;
    int   shorts;
    en_before = m_en; shorts = 0;
    io.btn = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      got = {io.sw_stable, io.sw_changed, io.btn_short, io.btn_long, io.cnt_en, io.cnt_rst};
      exp = {m_db[2:1], m_chg, m_short, m_long, m_en, m_rst};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL glitch_cyc%0d: got %b expected %b", c, got, exp);
      end
      if (io.btn_short) shorts++;
      if (c == 3) io.btn = 1'b0;
    end
    checks++;
    if (shorts !== 0) begin
      errors++; $display("FAIL glitch_short_count: got %0d expected 0", shorts);
    end
    checks++;
    if (io.cnt_en !== en_before) begin
      errors++; $display("FAIL glitch_cnt_en: got %b expected %b", io.cnt_en, en_before);
    end
  endtask

  task automatic test_short_press();
    logic [6:0] got, exp;
    int shorts, at;
    for (int rep = 0; rep < 2; rep++) begin
      shorts = 0; at = -1;
      io.btn = 1'b1;
      for (int c = 1; c <= 30; c++) begin
        tick();
        got = {io.sw_stable, io.sw_changed, io.btn_short, io.btn_long, io.cnt_en, io.cnt_rst};
        exp = {m_db[2:1], m_chg, m_short, m_long, m_en, m_rst};
        checks++;
        if (got !== exp) begin
          errors++; $display("FAIL short%0d_cyc%0d: got %b expected %b", rep, c, got, exp);
        end
        if (io.btn_short) begin shorts++; at = c; end
        if (c == 10) io.btn = 1'b0;
      end
      checks++;
      if (shorts !== 1 || at !== 17) begin
        errors++; $display("FAIL short%0d_pulse: got count %0d at %0d expected count 1 at 17", rep, shorts, at);
      end
      checks++;
      if (io.cnt_en !== ((rep == 0) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL short%0d_cnt_en: got %b expected %b", rep, io.cnt_en, (rep == 0));
      end
    end
  endtask

  // holds the button 40 cycles; which pulses appear depends on the long-press build
  task automatic hold_40(input string tag, output int shorts, output int short_at,
                         output int longs, output int long_at, output int rsts, output int rst_at);
    logic [6:0] got, exp;
    shorts = 0; short_at = -1; longs = 0; long_at = -1; rsts = 0; rst_at = -1;
    io.btn = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      got = {io.sw_stable, io.sw_changed, io.btn_short, io.btn_long, io.cnt_en, io.cnt_rst};
      exp = {m_db[2:1], m_chg, m_short, m_long, m_en, m_rst};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL %s_cyc%0d: got %b expected %b", tag, c, got, exp);
      end
      if (io.btn_short) begin shorts++; short_at = c; end
      if (io.btn_long)  begin longs++;  long_at  = c; end
      if (io.cnt_rst)   begin rsts++;   rst_at   = c; end
      if (c == 40) io.btn = 1'b0;
    end
  endtask

  task automatic test_long_press();
    int s, sa, l, la, r, ra;
    io.btn = 1'b1;
    repeat (10) tick();
    io.btn = 1'b0;
    repeat (12) tick();
    checks++;
    if (io.cnt_en !== 1'b1) begin
      errors++; $display("FAIL long_pre_cnt_en: got %b expected 1", io.cnt_en);
    end
    hold_40("long", s, sa, l, la, r, ra);
    checks++;
    if (l !== 1 || la !== 27) begin
      errors++; $display("FAIL long_pulse: got count %0d at %0d expected count 1 at 27", l, la);
    end
    checks++;
    if (r !== 1 || ra !== 27) begin
      errors++; $display("FAIL long_cnt_rst: got count %0d at %0d expected count 1 at 27", r, ra);
    end
    checks++;
    if (s !== 0) begin
      errors++; $display("FAIL long_no_short: got %0d expected 0", s);
    end
    checks++;
    if (io.cnt_en !== 1'b0) begin
      errors++; $display("FAIL long_cnt_en: got %b expected 0", io.cnt_en);
    end
  endtask

  task automatic test_no_long();
    int s, sa, l, la, r, ra;
    hold_40("nolong", s, sa, l, la, r, ra);
    checks++;
    if (s !== 1 || sa !== 47) begin
      errors++; $display("FAIL nolong_short: got count %0d at %0d expected count 1 at 47", s, sa);
    end
    checks++;
    if (l !== 0 || r !== 0) begin
      errors++; $display("FAIL nolong_long_rst: got long %0d rst %0d expected 0 and 0", l, r);
    end
  endtask

  task automatic test_switches();
    logic [6:0] got, exp;
    int chg, at;
    chg = 0; at = -1;
    io.switches = 2'b10;
    for (int c = 1; c <= 20; c++) begin
      tick();
      got = {io.sw_stable, io.sw_changed, io.btn_short, io.btn_long, io.cnt_en, io.cnt_rst};
      exp = {m_db[2:1], m_chg, m_short, m_long, m_en, m_rst};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL sw_cyc%0d: got %b expected %b", c, got, exp);
      end
      if (io.sw_changed) begin chg++; at = c; end
      if (c == 6) io.switches = 2'b00;
      if (c == 8) io.switches = 2'b10;
    end
    checks++;
    if (chg !== 1 || at !== 7) begin
      errors++; $display("FAIL sw_changed: got count %0d at %0d expected count 1 at 7", chg, at);
    end
    checks++;
    if (io.sw_stable !== 2'b10) begin
      errors++; $display("FAIL sw_stable: got %b expected 10", io.sw_stable);
    end
  endtask

  task automatic test_reset_mid_press();
    logic [6:0] got, exp;
    int shorts, at;
    shorts = 0; at = -1;
    io.btn = 1'b1;
    repeat (12) tick();
    #2;
    rst_n = 1'b0;
    #1;
    got = {io.sw_stable, io.sw_changed, io.btn_short, io.btn_long, io.cnt_en, io.cnt_rst};
    checks++;
    if (got !== 7'b0000000) begin
      errors++; $display("FAIL rstmid_async: got %b expected %b", got, 7'b0000000);
    end
    model_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      got = {io.sw_stable, io.sw_changed, io.btn_short, io.btn_long, io.cnt_en, io.cnt_rst};
      exp = {m_db[2:1], m_chg, m_short, m_long, m_en, m_rst};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL rstmid_cyc%0d: got %b expected %b", c, got, exp);
      end
      if (io.btn_short) begin shorts++; at = c; end
      if (c == 10) io.btn = 1'b0;
    end
    checks++;
    if (shorts !== 1 || at !== 17) begin
      errors++; $display("FAIL rstmid_short: got count %0d at %0d expected count 1 at 17", shorts, at);
    end
  endtask

  task automatic test_random();
    logic [6:0] got, exp;
    int btn_left, sw_left;
    btn_left = 0; sw_left = 0;
    for (int c = 1; c <= 800; c++) begin
      if (btn_left == 0) begin
        io.btn   = ~io.btn;
        btn_left = int'($urandom_range(1, 30));
      end else begin
        btn_left--;
      end
      if (sw_left == 0) begin
        io.switches = 2'($urandom_range(0, 3));
        sw_left     = int'($urandom_range(1, 12));
      end else begin
        sw_left--;
      end
      tick();
      got = {io.sw_stable, io.sw_changed, io.btn_short, io.btn_long, io.cnt_en, io.cnt_rst};
      exp = {m_db[2:1], m_chg, m_short, m_long, m_en, m_rst};
      checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random_cyc%0d: got %b expected %b", c, got, exp);
      end
    end
  endtask

  initial begin
    io.btn      = 1'b0;
    io.switches = 2'b00;
    model_reset();
    test_reset();
    test_glitch();
    test_short_press();
`ifdef INPUT_COND_LONG_PRESS_EN
    test_long_press();
`else
    test_no_long();
`endif
    test_switches();
    test_reset_mid_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
